clk_div_cfg_ctrl: RTL and testbench

- Reconfiguration sequencer for one programmable clock divider instance.
- Accepts divide-ratio change requests over a valid/ready handshake.
- Applies each change safely: disables the divider, drains, loads the new ratio, re-enables, then waits one full output period before reporting completion.
- Sits between the register file / system controller and the divider's enable and ratio inputs, so the ratio never changes while the divider is running.

---
 rtl/clk_div_cfg_ctrl.sv | 129 ++++++++++++
 tb/tb_clk_div_cfg_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_cfg_ctrl.sv
// Reconfiguration sequencer for a programmable clock divider: accepts ratio changes over
// valid/ready and applies them only while the divider is disabled, then waits one output period.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | enable tracks i_enable, ready for a new ratio request
// DISABLE  | divider held off for DRAIN_CYC cycles to let it drain
// LOAD     | new ratio driven to the divider while still disabled
// ENABLE   | divider re-enabled, settle timer armed from the new ratio
// SETTLE   | wait one full output period, then pulse o_done
module clk_div_cfg_ctrl #(
    parameter int DIV_RATIO_WIDTH = 8,
    parameter int DRAIN_CYC       = 2,
    parameter int RESET_RATIO     = 1
) (
    input  logic                       i_ref_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enable,
    input  logic                       i_cfg_valid,
    input  logic [DIV_RATIO_WIDTH-1:0] i_cfg_ratio,
    output logic                       o_cfg_ready,
    output logic [DIV_RATIO_WIDTH-1:0] o_div_ratio,
    output logic                       o_clk_en,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam logic [3:0]                 DRAIN_INIT = 4'(DRAIN_CYC - 1);
    localparam logic [DIV_RATIO_WIDTH-1:0] RST_RATIO  = DIV_RATIO_WIDTH'(RESET_RATIO);
    localparam logic [DIV_RATIO_WIDTH-1:0] RATIO_ONE  = DIV_RATIO_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISABLE,
        S_LOAD,
        S_ENABLE,
        S_SETTLE
    } state_t;

    state_t                       state_q, state_d;
    logic [DIV_RATIO_WIDTH-1:0]   ratio_q, ratio_d;
    logic [DIV_RATIO_WIDTH-1:0]   pending_q, pending_d;
    logic [DIV_RATIO_WIDTH-1:0]   settle_q, settle_d;
    logic [3:0]                   drain_q, drain_d;
    logic                         clk_en_q, clk_en_d;
    logic                         done_q, done_d;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            ratio_q   <= RST_RATIO;
            pending_q <= RST_RATIO;
            settle_q  <= '0;
            drain_q   <= '0;
            clk_en_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ratio_q   <= ratio_d;
            pending_q <= pending_d;
            settle_q  <= settle_d;
            drain_q   <= drain_d;
            clk_en_q  <= clk_en_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ratio_d   = ratio_q;
        pending_d = pending_q;
        settle_d  = settle_q;
        drain_d   = drain_q;
        clk_en_d  = clk_en_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_en_d = i_enable;
                if (i_cfg_valid) begin
                    // Same ratio on a running divider needs no disable/reload cycle.
                    if ((i_cfg_ratio == ratio_q) && clk_en_q) begin
                        done_d = 1'b1;
                    end else begin
                        pending_d = i_cfg_ratio;
                        clk_en_d  = 1'b0;
                        drain_d   = DRAIN_INIT;
                        state_d   = S_DISABLE;
                    end
                end
            end
            S_DISABLE: begin
                clk_en_d = 1'b0;
                if (drain_q == 4'd0) state_d = S_LOAD;
                else                 drain_d = drain_q - 4'd1;
            end
            S_LOAD: begin
                clk_en_d = 1'b0;
                ratio_d  = pending_q;
                state_d  = S_ENABLE;
            end
            S_ENABLE: begin
                clk_en_d = i_enable;
                // Ratio 0 bypasses like ratio 1, so it settles in a single cycle.
                settle_d = (pending_q == '0) ? '0 : (pending_q - RATIO_ONE);
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                clk_en_d = i_enable;
                if (settle_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    settle_d = settle_q - RATIO_ONE;
                end
            end
            default: begin
                clk_en_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign o_cfg_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_div_ratio = ratio_q;
    assign o_clk_en    = clk_en_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl: reset state, a traced reconfiguration, a table of
// requests with hand-computed latencies, and back-to-back, reset and enable-drop corner cases.
module tb_clk_div_cfg_ctrl;

    logic       i_ref_clk = 1'b0;
    logic       i_rst_n;
    logic       i_enable;
    logic       i_cfg_valid;
    logic [7:0] i_cfg_ratio;
    logic       o_cfg_ready;
    logic [7:0] o_div_ratio;
    logic       o_clk_en;
    logic       o_busy;
    logic       o_done;

    int checks = 0;
    int errors = 0;

    clk_div_cfg_ctrl #(
        .DIV_RATIO_WIDTH(8),
        .DRAIN_CYC      (2),
        .RESET_RATIO    (1)
    ) dut (
        .i_ref_clk  (i_ref_clk),
        .i_rst_n    (i_rst_n),
        .i_enable   (i_enable),
        .i_cfg_valid(i_cfg_valid),
        .i_cfg_ratio(i_cfg_ratio),
        .o_cfg_ready(o_cfg_ready),
        .o_div_ratio(o_div_ratio),
        .o_clk_en   (o_clk_en),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial forever #5 i_ref_clk = ~i_ref_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_ref_clk);
        #1;
    endtask

    // The divider ratio may only move while its enable is low.
    logic [7:0] prev_ratio = 8'd1;
    always @(negedge i_ref_clk) begin
        if (i_rst_n === 1'b1 && o_div_ratio !== prev_ratio)
            check("ratio_change_while_enabled", {31'd0, o_clk_en}, 32'd0);
        prev_ratio = o_div_ratio;
    end

    // k = edge index (accept edge = 0) after which o_done is seen high.
    task automatic run_req(input logic [7:0] r, output int k, output logic busy0);
        logic seen;
        i_cfg_ratio = r;
        i_cfg_valid = 1'b1;
        check("ready_before_req", {31'd0, o_cfg_ready}, 32'd1);
        tick();
        i_cfg_valid = 1'b0;
        busy0 = o_busy;
        k = 0;
        seen = o_done;
        while (!seen && k < 400) begin
            tick();
            k++;
            seen = o_done;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("ratio_at_done", {24'd0, o_div_ratio}, {24'd0, r});
        check("busy_at_done", {31'd0, o_busy}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, o_done}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] ratio;
        int         exp_k;
        logic       fast;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        int   k;
        logic busy0;
        int   ndone, d1, d2;
        logic [7:0] r1, r2;

        // Current ratio is 4 when the table starts; DRAIN_CYC = 2.
        vecs[0] = '{8'd4,   0,   1'b1};
        vecs[1] = '{8'd0,   5,   1'b0};
        vecs[2] = '{8'd1,   5,   1'b0};
        vecs[3] = '{8'd1,   0,   1'b1};
        vecs[4] = '{8'd9,   13,  1'b0};
        vecs[5] = '{8'd255, 259, 1'b0};
        vecs[6] = '{8'd2,   6,   1'b0};

        i_rst_n     = 1'b0;
        i_enable    = 1'b1;
        i_cfg_valid = 1'b0;
        i_cfg_ratio = 8'd0;

        repeat (3) tick();
        check("rst_ratio",  {24'd0, o_div_ratio}, 32'd1);
        check("rst_clk_en", {31'd0, o_clk_en}, 32'd0);
        check("rst_ready",  {31'd0, o_cfg_ready}, 32'd1);
        check("rst_done",   {31'd0, o_done}, 32'd0);
        check("rst_busy",   {31'd0, o_busy}, 32'd0);
        i_rst_n = 1'b1;
        #1;
        check("clk_en_at_release", {31'd0, o_clk_en}, 32'd0);
        tick();
        check("clk_en_after_release", {31'd0, o_clk_en}, 32'd1);

        // Traced sequence: ratio 1 -> 4.
        i_cfg_ratio = 8'd4;
        i_cfg_valid = 1'b1;
        tick();
        i_cfg_valid = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            if (e > 0) tick();
            check("trace_clk_en", {31'd0, o_clk_en},    (e >= 4) ? 32'd1 : 32'd0);
            check("trace_ratio",  {24'd0, o_div_ratio}, (e >= 3) ? 32'd4 : 32'd1);
            check("trace_ready",  {31'd0, o_cfg_ready}, (e == 8) ? 32'd1 : 32'd0);
            check("trace_done",   {31'd0, o_done},      (e == 8) ? 32'd1 : 32'd0);
        end
        tick();

        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i].ratio, k, busy0);
            check("vec_latency", k, vecs[i].exp_k);
            check("vec_busy_after_accept", {31'd0, busy0}, {31'd0, ~vecs[i].fast});
        end

        // Reset during SETTLE of 2 -> 6.
        i_cfg_ratio = 8'd6;
        i_cfg_valid = 1'b1;
        tick();
        i_cfg_valid = 1'b0;
        repeat (6) tick();
        check("mid_busy", {31'd0, o_busy}, 32'd1);
        check("mid_ratio", {24'd0, o_div_ratio}, 32'd6);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_ratio",  {24'd0, o_div_ratio}, 32'd1);
        check("mid_rst_clk_en", {31'd0, o_clk_en}, 32'd0);
        check("mid_rst_busy",   {31'd0, o_busy}, 32'd0);
        for (int e = 0; e < 8; e++) begin
            if (e == 3) i_rst_n = 1'b1;
            tick();
            check("mid_rst_no_done", {31'd0, o_done}, 32'd0);
        end
        check("post_rst_clk_en", {31'd0, o_clk_en}, 32'd1);

        // Enable dropped during SETTLE of 1 -> 5.
        i_cfg_ratio = 8'd5;
        i_cfg_valid = 1'b1;
        tick();
        i_cfg_valid = 1'b0;
        repeat (5) tick();
        check("drop_clk_en_before", {31'd0, o_clk_en}, 32'd1);
        i_enable = 1'b0;
        tick();
        check("drop_clk_en_after", {31'd0, o_clk_en}, 32'd0);
        check("drop_busy", {31'd0, o_busy}, 32'd1);
        repeat (2) tick();
        check("drop_done_early", {31'd0, o_done}, 32'd0);
        tick();
        check("drop_done", {31'd0, o_done}, 32'd1);
        check("drop_ratio", {24'd0, o_div_ratio}, 32'd5);
        i_enable = 1'b1;
        tick();
        check("drop_reenable", {31'd0, o_clk_en}, 32'd1);

        // Back-to-back: 5 -> 7, then 3 held valid until the done cycle.
        ndone = 0; d1 = -1; d2 = -1; r1 = 8'd0; r2 = 8'd0;
        i_cfg_ratio = 8'd7;
        i_cfg_valid = 1'b1;
        tick();
        i_cfg_ratio = 8'd3;
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (o_done) begin
                ndone++;
                if (ndone == 1) begin d1 = e; r1 = o_div_ratio; end
                else            begin d2 = e; r2 = o_div_ratio; end
            end
            if (e == 12) begin
                check("b2b_second_accepted", {31'd0, o_busy}, 32'd1);
                i_cfg_valid = 1'b0;
            end
        end
        check("b2b_done_count", ndone, 32'd2);
        check("b2b_first_done_edge", d1, 32'd11);
        check("b2b_second_done_edge", d2, 32'd19);
        check("b2b_first_ratio", {24'd0, r1}, 32'd7);
        check("b2b_second_ratio", {24'd0, r2}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
